lm07_spi_target: RTL and testbench

- SPI target (responder) that emulates the LM07 temperature sensor. It serves a temperature word to an SPI master such as the team's LM07 reader.
- Placement: board bring-up, FPGA loopback tests and sensor-less builds. The block sits on the CS/SCK/SIO pins in place of the physical sensor.
- Fully synchronous to SYSCLK. CS and SCK are treated as asynchronous inputs and are oversampled.

---
 rtl/lm07_pkg.sv | 16 +
 rtl/lm07_sync_edge.sv | 33 +++
 rtl/lm07_spi_target.sv | 168 ++++++++++++++++
 tb/tb_lm07_spi_target.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lm07_pkg.sv
// Shared definitions for the LM07 sensor emulation blocks.
package lm07_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } lm07_state_e;

  localparam int unsigned LM07_DATA_W = 8;

  // Pin levels of an idle bus: CS deasserted, SCK low.
  localparam logic LM07_CS_IDLE  = 1'b1;
  localparam logic LM07_SCK_IDLE = 1'b0;

endpackage

// File: rtl/lm07_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module lm07_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic SYSCLK,
  input  logic RSTN,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Synchronizer chain plus one extra flop holding the previous level.
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/lm07_spi_target.sv
// LM07 temperature sensor emulation: SPI target that shifts a held
// temperature word out on SIO, MSB first, changing data after SCK falls.
// Optional frame counter output enabled by defining LM07_TGT_FRAME_CNT_EN.
module lm07_spi_target
  import lm07_pkg::*;
#(
  parameter int unsigned DATA_W      = LM07_DATA_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic              SYSCLK,
  input  logic              RSTN,
  input  logic              CS,
  input  logic              SCK,
  output logic              SIO,
  output logic              SIO_OE,
  input  logic [DATA_W-1:0] temp_data,
  input  logic              temp_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
`ifdef LM07_TGT_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  lm07_state_e       state, state_n;
  logic [DATA_W-1:0] hold, shreg, shreg_n, load_val;
  logic [CNT_W-1:0]  bitcnt, bitcnt_n, cnt_inc;
  logic              sio_n, ovf, ovf_n, done_n, err_n;
  logic              cs_level, cs_rise, cs_fall;
  logic              sck_level, sck_rise, sck_fall;
  logic [SYNC_STAGES:0] settle;
  logic              armed;

  lm07_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (LM07_CS_IDLE)
  ) u_cs_sync (
    .SYSCLK (SYSCLK),
    .RSTN   (RSTN),
    .din    (CS),
    .level  (cs_level),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  lm07_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (LM07_SCK_IDLE)
  ) u_sck_sync (
    .SYSCLK (SYSCLK),
    .RSTN   (RSTN),
    .din    (SCK),
    .level  (sck_level),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  assign load_val = temp_valid ? temp_data : hold;
  assign cnt_inc  = bitcnt + CNT_W'(1);

  // Holding register: any strobe loads it; the frame copy lives in shreg.
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN)           hold <= '0;
    else if (temp_valid) hold <= temp_data;
  end

  // Arm frame start only after the synchronizers reflect the pins and the
  // bus has been seen idle, so a CS held low through reset is ignored.
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      if (settle[SYNC_STAGES] && cs_level == LM07_CS_IDLE && sck_level == LM07_SCK_IDLE)
        armed <= 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      ovf        <= 1'b0;
      SIO        <= IDLE_LEVEL;
      SIO_OE     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bitcnt     <= bitcnt_n;
      ovf        <= ovf_n;
      SIO        <= sio_n;
      SIO_OE     <= (state_n != IDLE);
      busy       <= (state_n != IDLE);
      frame_done <= done_n;
      frame_err  <= err_n;
    end
  end

  // Next-state logic; cs_rise outranks any SCK edge in the same cycle.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    ovf_n    = ovf;
    sio_n    = SIO;
    done_n   = 1'b0;
    err_n    = 1'b0;
    unique case (state)
      IDLE: begin
        sio_n = IDLE_LEVEL;
        ovf_n = 1'b0;
        if (cs_fall && armed) begin
          shreg_n  = load_val;
          bitcnt_n = '0;
          sio_n    = load_val[DATA_W-1];
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          err_n   = 1'b1;
          sio_n   = IDLE_LEVEL;
          state_n = IDLE;
        end else if (sck_rise) begin
          bitcnt_n = cnt_inc;
          if (cnt_inc == CNT_W'(DATA_W)) begin
            sio_n   = IDLE_LEVEL;
            state_n = TAIL;
          end
        end else if (sck_fall) begin
          shreg_n = {shreg[DATA_W-2:0], IDLE_LEVEL};
          sio_n   = shreg[DATA_W-2];
        end
      end
      TAIL: begin
        sio_n = IDLE_LEVEL;
        if (cs_rise) begin
          done_n  = ~ovf;
          err_n   = ovf;
          state_n = IDLE;
        end else if (sck_rise) begin
          ovf_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef LM07_TGT_FRAME_CNT_EN
  // Count completed frames only; wraps naturally at 16 bits.
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN)       frame_cnt <= '0;
    else if (done_n) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lm07_spi_target.sv
// Directed bench for lm07_spi_target acting as the SPI master.
module tb_lm07_spi_target;

  logic       SYSCLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       CS = 1'b1;
  logic       SCK = 1'b0;
  logic       SIO, SIO_OE, busy, frame_done, frame_err;
  logic [7:0] temp_data = '0;
  logic       temp_valid = 1'b0;
`ifdef LM07_TGT_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [15:0] rx;
  logic        oe_mid, busy_mid;

  always #5 SYSCLK = ~SYSCLK;

  lm07_spi_target #(
    .DATA_W      (8),
    .SYNC_STAGES (2),
    .IDLE_LEVEL  (1'b0)
  ) dut (
    .SYSCLK     (SYSCLK),
    .RSTN       (RSTN),
    .CS         (CS),
    .SCK        (SCK),
    .SIO        (SIO),
    .SIO_OE     (SIO_OE),
    .temp_data  (temp_data),
    .temp_valid (temp_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
`ifdef LM07_TGT_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always @(negedge SYSCLK) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge SYSCLK);
    temp_data  = v;
    temp_valid = 1'b1;
    @(negedge SYSCLK);
    temp_valid = 1'b0;
  endtask

  // One master frame: nrise SCK periods of 16 SYSCLK; optional mid-frame
  // load before rise number load_at, optional strobe aligned with cs_fall.
  task automatic run_frame(input int nrise, input int load_at, input logic [7:0] load_v,
                           input bit byp, output logic [15:0] r,
                           output logic oe_m, output logic busy_m);
    done_cnt = 0;
    err_cnt  = 0;
    r = '0;
    @(negedge SYSCLK);
    CS = 1'b0;
    if (byp) begin
      repeat (2) @(negedge SYSCLK);
      temp_data  = load_v;
      temp_valid = 1'b1;
      @(negedge SYSCLK);
      temp_valid = 1'b0;
      repeat (5) @(negedge SYSCLK);
    end else begin
      repeat (8) @(negedge SYSCLK);
    end
    oe_m   = SIO_OE;
    busy_m = busy;
    for (int i = 0; i < nrise; i++) begin
      if (i == load_at) load(load_v);
      r = {r[14:0], SIO};
      SCK = 1'b1;
      repeat (8) @(negedge SYSCLK);
      SCK = 1'b0;
      repeat (8) @(negedge SYSCLK);
    end
    CS = 1'b1;
    repeat (10) @(negedge SYSCLK);
  endtask

  initial begin
    repeat (3) @(negedge SYSCLK);
    check("rst_sio", 32'(SIO), 32'd0);
    check("rst_oe", 32'(SIO_OE), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    RSTN = 1'b1;
    repeat (10) @(negedge SYSCLK);

    // Basic shift of A5
    load(8'hA5);
    run_frame(8, -1, 8'h00, 1'b0, rx, oe_mid, busy_mid);
    check("a5_data", 32'(rx[7:0]), 32'hA5);
    check("a5_oe_mid", 32'(oe_mid), 32'd1);
    check("a5_busy_mid", 32'(busy_mid), 32'd1);
    check("a5_done", 32'(done_cnt), 32'd1);
    check("a5_err", 32'(err_cnt), 32'd0);
    check("a5_oe_end", 32'(SIO_OE), 32'd0);
    check("a5_busy_end", 32'(busy), 32'd0);
    check("a5_sio_end", 32'(SIO), 32'd0);

    // Atomicity: 3C loaded mid-frame does not disturb A5
    run_frame(8, 3, 8'h3C, 1'b0, rx, oe_mid, busy_mid);
    check("atom_cur", 32'(rx[7:0]), 32'hA5);
    check("atom_done", 32'(done_cnt), 32'd1);
    run_frame(8, -1, 8'h00, 1'b0, rx, oe_mid, busy_mid);
    check("atom_next", 32'(rx[7:0]), 32'h3C);

    // Short frame: 5 rises of 3C -> 00111
    run_frame(5, -1, 8'h00, 1'b0, rx, oe_mid, busy_mid);
    check("short_data", 32'(rx[4:0]), 32'h07);
    check("short_err", 32'(err_cnt), 32'd1);
    check("short_done", 32'(done_cnt), 32'd0);
    check("short_busy", 32'(busy), 32'd0);
    check("short_sio", 32'(SIO), 32'd0);

    // Overclock: 10 rises of 3C -> 0011110000
    run_frame(10, -1, 8'h00, 1'b0, rx, oe_mid, busy_mid);
    check("ovf_data", 32'(rx[9:0]), 32'h0F0);
    check("ovf_err", 32'(err_cnt), 32'd1);
    check("ovf_done", 32'(done_cnt), 32'd0);

    // Strobe in the cs_fall cycle is used directly
    run_frame(8, -1, 8'h5A, 1'b1, rx, oe_mid, busy_mid);
    check("byp_data", 32'(rx[7:0]), 32'h5A);
    check("byp_done", 32'(done_cnt), 32'd1);

    // Reset mid-frame with CS held low through the release
    @(negedge SYSCLK);
    CS = 1'b0;
    repeat (8) @(negedge SYSCLK);
    for (int i = 0; i < 3; i++) begin
      SCK = 1'b1;
      repeat (8) @(negedge SYSCLK);
      SCK = 1'b0;
      repeat (8) @(negedge SYSCLK);
    end
    check("mid_busy_pre", 32'(busy), 32'd1);
    RSTN = 1'b0;
    @(negedge SYSCLK);
    check("mid_rst_sio", 32'(SIO), 32'd0);
    check("mid_rst_oe", 32'(SIO_OE), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    RSTN = 1'b1;
    repeat (12) @(negedge SYSCLK);
    check("mid_lowcs_busy", 32'(busy), 32'd0);
    check("mid_lowcs_oe", 32'(SIO_OE), 32'd0);
    CS = 1'b1;
    repeat (8) @(negedge SYSCLK);
    run_frame(8, -1, 8'h00, 1'b0, rx, oe_mid, busy_mid);
    check("mid_next_data", 32'(rx[7:0]), 32'h00);
    check("mid_next_done", 32'(done_cnt), 32'd1);

`ifdef LM07_TGT_FRAME_CNT_EN
    check("cnt_after_rst", 32'(frame_cnt), 32'd1);
    load(8'h81);
    run_frame(8, -1, 8'h00, 1'b0, rx, oe_mid, busy_mid);
    run_frame(8, -1, 8'h00, 1'b0, rx, oe_mid, busy_mid);
    run_frame(4, -1, 8'h00, 1'b0, rx, oe_mid, busy_mid);
    check("cnt_three", 32'(frame_cnt), 32'd3);
    @(negedge SYSCLK);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge SYSCLK);
    release dut.frame_cnt;
    run_frame(8, -1, 8'h00, 1'b0, rx, oe_mid, busy_mid);
    check("cnt_wrap", 32'(frame_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
